// File: rtl/mul_arbiter_if.sv
// Request/response and multiplier-control bundle shared by mul_arbiter and its environment.
// req_i is a level with a0/b0 or a1/b1 held stable until ack_i; ack_i and done_i are one-cycle pulses.
interface mul_arbiter_if #(
  parameter int WIDTH = 32
);
  logic                 req0;
  logic                 req1;
  logic [WIDTH-1:0]     a0;
  logic [WIDTH-1:0]     b0;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 ack0;
  logic                 ack1;
  logic                 done0;
  logic                 done1;
  logic [2*WIDTH-1:0]   result;
  logic                 err;
  logic                 busy;
  logic                 mul_Reset;
  logic                 mul_Run;
  logic [WIDTH-1:0]     mul_Multiplicand;
  logic [WIDTH-1:0]     mul_Multiplier;
  logic                 mul_Ready;
  logic [2*WIDTH-1:0]   mul_Product;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_Ready, mul_Product,
    output ack0, ack1, done0, done1, result, err, busy,
           mul_Reset, mul_Run, mul_Multiplicand, mul_Multiplier
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_Ready, mul_Product,
    input  ack0, ack1, done0, done1, result, err, busy,
           mul_Reset, mul_Run, mul_Multiplicand, mul_Multiplier
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer for a shared shift-add multiplier with a watchdog abort.
module mul_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         Reset,
  mul_arbiter_if.slave bus,
  output logic [1:0]   o_state,
  output logic         o_last
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_last;
  logic                 r_owner;
  logic                 r_ack0;
  logic                 r_ack1;
  logic                 r_done0;
  logic                 r_done1;
  logic                 r_err;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WD_W-1:0]      r_wd;

  logic                 w_req_any;
  logic                 w_grant1;

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign w_req_any = bus.req0 | bus.req1;
  assign w_grant1  = bus.req1 & (~bus.req0 | ~r_last);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_wd     <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner  <= w_grant1;
            r_last   <= w_grant1;
            r_ack0   <= ~w_grant1;
            r_ack1   <= w_grant1;
            r_mcand  <= w_grant1 ? bus.a1 : bus.a0;
            r_mplier <= w_grant1 ? bus.b1 : bus.b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_wd    <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.mul_Ready) begin
            r_result <= bus.mul_Product;
            r_err    <= 1'b0;
            r_done0  <= ~r_owner;
            r_done1  <= r_owner;
            r_state  <= S_DONE;
          end else if (r_wd == WD_LAST) begin
            // TIMEOUT-th RUN edge without Ready: abort with a zero result.
            r_result <= '0;
            r_err    <= 1'b1;
            r_done0  <= ~r_owner;
            r_done1  <= r_owner;
            r_state  <= S_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0             = r_ack0;
  assign bus.ack1             = r_ack1;
  assign bus.done0            = r_done0;
  assign bus.done1            = r_done1;
  assign bus.result           = r_result;
  assign bus.err              = r_err;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.mul_Reset        = Reset | (r_state == S_LOAD);
  assign bus.mul_Run          = (r_state == S_RUN);
  assign bus.mul_Multiplicand = r_mcand;
  assign bus.mul_Multiplier   = r_mplier;

  assign o_state = r_state;
  assign o_last  = r_last;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier of programmable latency.
module tb_mul_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       Reset;
  logic [1:0] dbg_state;
  logic       dbg_last;

  int total = 0;
  int bad   = 0;

  int          lat        = 3;
  bit          hold_ready = 1'b0;
  int          m_cnt      = 0;
  logic [31:0] m_a;
  logic [31:0] m_b;

  mul_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .bus     (bus),
    .o_state (dbg_state),
    .o_last  (dbg_last)
  );

  always #5 clk = ~clk;

  // Multiplier model: loads on mul_Reset, raises a sticky Ready after lat RUN cycles.
  always @(negedge clk) begin
    if (bus.mul_Reset) begin
      bus.mul_Ready   = 1'b0;
      bus.mul_Product = 64'hDEAD_BEEF_DEAD_BEEF;
      m_cnt = 0;
      m_a   = bus.mul_Multiplicand;
      m_b   = bus.mul_Multiplier;
    end else if (bus.mul_Run && !bus.mul_Ready) begin
      m_cnt++;
      if (!hold_ready && m_cnt >= lat) begin
        bus.mul_Ready   = 1'b1;
        bus.mul_Product = {32'b0, m_a} * {32'b0, m_b};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    check($sformatf("%s flags", tag),
          {56'b0, bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy, bus.mul_Run, bus.mul_Reset},
          64'h01);
    check($sformatf("%s result", tag), bus.result, 64'h0);
    check($sformatf("%s opnds", tag), {bus.mul_Multiplicand, bus.mul_Multiplier}, 64'h0);
    check($sformatf("%s state_last", tag), {61'b0, dbg_state, dbg_last}, 64'h1);
  endtask

  task automatic expect_ack(input bit who, input logic [31:0] ea, input logic [31:0] eb, input string tag);
    step();
    check($sformatf("%s ack", tag), {62'b0, bus.ack1, bus.ack0}, who ? 64'd2 : 64'd1);
    check($sformatf("%s load", tag), {61'b0, bus.mul_Reset, bus.mul_Run, bus.busy}, 64'b101);
    check($sformatf("%s opnds", tag), {bus.mul_Multiplicand, bus.mul_Multiplier}, {ea, eb});
    check($sformatf("%s last", tag), {63'b0, dbg_last}, {63'b0, who});
  endtask

  task automatic expect_run(input string tag);
    step();
    check($sformatf("%s run", tag),
          {59'b0, bus.ack1, bus.ack0, bus.mul_Reset, bus.mul_Run, bus.busy}, 64'b00011);
  endtask

  task automatic wait_done(input bit who, input int exp_n, input logic [63:0] exp_res,
                           input bit exp_err, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(bus.done0 || bus.done1) && n < exp_n + 20);
    check($sformatf("%s latency", tag), 64'(n), 64'(exp_n));
    check($sformatf("%s done", tag), {62'b0, bus.done1, bus.done0}, who ? 64'd2 : 64'd1);
    check($sformatf("%s result", tag), bus.result, exp_res);
    check($sformatf("%s err", tag), {63'b0, bus.err}, {63'b0, exp_err});
    check($sformatf("%s quiet", tag), {61'b0, bus.mul_Run, bus.ack1, bus.ack0}, 64'h0);
  endtask

  task automatic idle_check(input string tag, input logic [63:0] held);
    step();
    check($sformatf("%s idle", tag),
          {58'b0, bus.busy, bus.done1, bus.done0, bus.ack1, bus.ack0, bus.mul_Run}, 64'h0);
    check($sformatf("%s idle state", tag), {62'b0, dbg_state}, 64'h0);
    check($sformatf("%s held result", tag), bus.result, held);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit seen;
    Reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    step();
    reset_check("por");
    Reset = 1'b0;

    // Single job from requester 0
    lat = 3; bus.a0 = 32'd7; bus.b0 = 32'd6; bus.req0 = 1'b1;
    expect_ack(1'b0, 32'd7, 32'd6, "single");
    bus.req0 = 1'b0;
    expect_run("single");
    wait_done(1'b0, 3, 64'd42, 1'b0, "single");
    idle_check("single", 64'd42);

    // Contention from reset: order 0, 1, 0
    Reset = 1'b1;
    bus.a0 = 32'd3; bus.b0 = 32'd5; bus.a1 = 32'hFFFF_FFFF; bus.b1 = 32'd2;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    reset_check("cont_rst");
    Reset = 1'b0;
    lat = 2;
    expect_ack(1'b0, 32'd3, 32'd5, "cont0");
    expect_run("cont0");
    wait_done(1'b0, 2, 64'd15, 1'b0, "cont0");
    idle_check("cont0", 64'd15);
    expect_ack(1'b1, 32'hFFFF_FFFF, 32'd2, "cont1");
    expect_run("cont1");
    wait_done(1'b1, 2, 64'h1_FFFF_FFFE, 1'b0, "cont1");
    idle_check("cont1", 64'h1_FFFF_FFFE);
    expect_ack(1'b0, 32'd3, 32'd5, "cont2");
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    expect_run("cont2");
    wait_done(1'b0, 2, 64'd15, 1'b0, "cont2");
    idle_check("cont2", 64'd15);

    // Maximum operands on requester 1
    lat = 5; bus.a1 = 32'hFFFF_FFFF; bus.b1 = 32'hFFFF_FFFF; bus.req1 = 1'b1;
    expect_ack(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    bus.req1 = 1'b0;
    expect_run("max");
    wait_done(1'b1, 5, 64'hFFFF_FFFE_0000_0001, 1'b0, "max");
    idle_check("max", 64'hFFFF_FFFE_0000_0001);

    // Watchdog abort, then a normal job
    hold_ready = 1'b1; bus.a0 = 32'd9; bus.b0 = 32'd9; bus.req0 = 1'b1;
    expect_ack(1'b0, 32'd9, 32'd9, "wdog");
    bus.req0 = 1'b0;
    expect_run("wdog");
    wait_done(1'b0, TIMEOUT, 64'd0, 1'b1, "wdog");
    idle_check("wdog", 64'd0);
    hold_ready = 1'b0; lat = 2; bus.a0 = 32'd100; bus.b0 = 32'd200; bus.req0 = 1'b1;
    expect_ack(1'b0, 32'd100, 32'd200, "post_wdog");
    bus.req0 = 1'b0;
    expect_run("post_wdog");
    wait_done(1'b0, 2, 64'd20000, 1'b0, "post_wdog");
    idle_check("post_wdog", 64'd20000);

    // Stale Ready from the previous job must not end this one early
    lat = 4; bus.a0 = 32'd12345; bus.b0 = 32'd1000; bus.req0 = 1'b1;
    expect_ack(1'b0, 32'd12345, 32'd1000, "stale");
    bus.req0 = 1'b0;
    expect_run("stale");
    wait_done(1'b0, 4, 64'd12345000, 1'b0, "stale");
    idle_check("stale", 64'd12345000);

    // Reset in the middle of RUN abandons the job
    lat = 10; bus.a0 = 32'd5; bus.b0 = 32'd5; bus.req0 = 1'b1;
    expect_ack(1'b0, 32'd5, 32'd5, "midrst");
    bus.req0 = 1'b0;
    expect_run("midrst");
    step();
    step();
    Reset = 1'b1;
    step();
    reset_check("midrst_rst");
    Reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      step();
      seen = seen | bus.done0 | bus.done1 | bus.busy;
    end
    check("midrst no_done", {63'b0, seen}, 64'h0);
    lat = 2; bus.a0 = 32'd11; bus.b0 = 32'd13; bus.req0 = 1'b1;
    expect_ack(1'b0, 32'd11, 32'd13, "post_rst");
    bus.req0 = 1'b0;
    expect_run("post_rst");
    wait_done(1'b0, 2, 64'd143, 1'b0, "post_rst");
    idle_check("post_rst", 64'd143);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
